// File: rtl/vs_fifo.sv
// vs_fifo: valid/stall FIFO placed directly downstream of a valid/stall skid buffer.
// Absorbs producer bursts and presents them in order to a stallable consumer. The
// upstream stall is registered and raised SKID entries before full, so items the
// producer delivers in its one-cycle stall reaction still find a free slot.
//
// Ports:
//   clk       clock, all state updates on posedge
//   rst       asynchronous reset, active-low
//   valid_us  upstream data valid
//   data_us   upstream payload
//   stall_us  registered stall to upstream
//   valid_ds  downstream data valid (a transfer happens every cycle it is 1)
//   data_ds   downstream payload, the FIFO head (0 when empty)
//   stall_ds  downstream stall
//   count     current occupancy, 0..DEPTH
//   overflow  sticky: a write was dropped because the FIFO was full
module vs_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned K     = 2,
    parameter int unsigned SKID  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_us,
    input  logic [WIDTH-1:0] data_us,
    output logic             stall_us,
    output logic             valid_ds,
    output logic [WIDTH-1:0] data_ds,
    input  logic             stall_ds,
    output logic [K:0]       count,
    output logic             overflow
);

    localparam int unsigned DEPTH    = 2 ** K;
    localparam logic [K:0]  STALL_AT = (K + 1)'(DEPTH - SKID);
    localparam logic [K:0]  PTR_ONE  = {{K{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];

    logic [K:0] wptr_q, wptr_d;
    logic [K:0] rptr_q, rptr_d;
    logic       stall_us_q, stall_us_d;
    logic       overflow_q, overflow_d;

    logic       empty, full, push, pop;
    logic [K:0] count_next;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[K] != rptr_q[K]) && (wptr_q[K-1:0] == rptr_q[K-1:0]);

    assign valid_ds = ~empty & ~stall_ds;
    assign pop      = valid_ds;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign push     = valid_us & (~full | pop);

    assign data_ds  = empty ? '0 : mem[rptr_q[K-1:0]];
    assign count    = wptr_q - rptr_q;
    assign stall_us = stall_us_q;
    assign overflow = overflow_q;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        if (valid_us && full && !pop) begin
            overflow_d = 1'b1;
        end
        count_next = wptr_d - rptr_d;
        stall_us_d = (count_next >= STALL_AT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            stall_us_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            stall_us_q <= stall_us_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: resetting the pointers empties the FIFO and masks data_ds.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[K-1:0]] <= data_us;
        end
    end

endmodule

// File: tb/tb_vs_fifo.sv
// Directed testbench for vs_fifo (WIDTH=8, K=2, SKID=1). Inputs change 1 time unit
// after posedge; outputs are checked 1 time unit later, well away from the clock edge.
module tb_vs_fifo;

    logic       clk;
    logic       rst;
    logic       valid_us;
    logic [7:0] data_us;
    logic       stall_us;
    logic       valid_ds;
    logic [7:0] data_ds;
    logic       stall_ds;
    logic [2:0] count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    vs_fifo #(
        .WIDTH(8),
        .K    (2),
        .SKID (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_us(valid_us),
        .data_us (data_us),
        .stall_us(stall_us),
        .valid_ds(valid_ds),
        .data_ds (data_ds),
        .stall_ds(stall_ds),
        .count   (count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; leave time 1 unit after the edge for driving inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change, then check.
    task automatic settle();
        #1;
    endtask

    task automatic check_state(input string tag, input logic [2:0] c, input logic su,
                               input logic vd, input logic ov);
        check_eq({tag, "_count"}, 32'(count), 32'(c));
        check_eq({tag, "_stall_us"}, 32'(stall_us), 32'(su));
        check_eq({tag, "_valid_ds"}, 32'(valid_ds), 32'(vd));
        check_eq({tag, "_overflow"}, 32'(overflow), 32'(ov));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        settle();
    endtask

    initial begin
        logic [7:0] fill_vals [4];
        logic [7:0] drain_vals [4];
        logic [2:0] drain_cnt [4];
        logic       drain_su [4];
        fill_vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        drain_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        // Count seen during each drain cycle, and stall_us in that cycle.
        drain_cnt  = '{3'd4, 3'd3, 3'd2, 3'd1};
        drain_su   = '{1'b1, 1'b1, 1'b0, 1'b0};

        rst      = 1'b0;
        valid_us = 1'b0;
        data_us  = 8'h00;
        stall_ds = 1'b1;
        #3;
        check_state("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        check_eq("reset_data_ds", 32'(data_ds), 32'h0);
        tick();
        rst = 1'b1;
        settle();

        // Fill under stall: count 1,2,3; stall_us rises in the cycle count reaches 3.
        for (int i = 0; i < 3; i++) begin
            valid_us = 1'b1;
            data_us  = fill_vals[i];
            tick();
            settle();
            check_state($sformatf("fill%0d", i), 3'(i + 1), (i == 2), 1'b0, 1'b0);
        end
        // Skid entry accepted.
        data_us = 8'h44;
        tick();
        settle();
        check_state("skid", 3'd4, 1'b1, 1'b0, 1'b0);
        // Full and no pop: dropped, overflow set.
        data_us = 8'h55;
        tick();
        valid_us = 1'b0;
        settle();
        check_state("drop", 3'd4, 1'b1, 1'b0, 1'b1);
        tick();
        settle();
        check_eq("drop_sticky", 32'(overflow), 32'h1);

        // Drain.
        stall_ds = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("drain%0d_valid", i), 32'(valid_ds), 32'h1);
            check_eq($sformatf("drain%0d_data", i), 32'(data_ds), 32'(drain_vals[i]));
            check_eq($sformatf("drain%0d_count", i), 32'(count), 32'(drain_cnt[i]));
            check_eq($sformatf("drain%0d_stall_us", i), 32'(stall_us), 32'(drain_su[i]));
            tick();
            settle();
        end
        check_state("drained", 3'd0, 1'b0, 1'b0, 1'b1);
        check_eq("drained_data", 32'(data_ds), 32'h0);

        // Latency from empty.
        valid_us = 1'b1;
        data_us  = 8'hA5;
        settle();
        check_eq("lat_before", 32'(valid_ds), 32'h0);
        tick();
        valid_us = 1'b0;
        settle();
        check_eq("lat_valid", 32'(valid_ds), 32'h1);
        check_eq("lat_data", 32'(data_ds), 32'hA5);
        check_eq("lat_count", 32'(count), 32'h1);
        tick();
        settle();
        check_eq("lat_count0", 32'(count), 32'h0);
        check_eq("lat_valid0", 32'(valid_ds), 32'h0);

        // Clear sticky overflow for the full/simultaneous case.
        do_reset();
        check_eq("rst2_overflow", 32'(overflow), 32'h0);

        stall_ds = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            valid_us = 1'b1;
            data_us  = 8'(i);
            tick();
        end
        settle();
        check_state("full", 3'd4, 1'b1, 1'b0, 1'b0);
        // Release stall while pushing 0x05, 0x06 into a full FIFO.
        stall_ds = 1'b0;
        for (int i = 5; i <= 6; i++) begin
            data_us = 8'(i);
            settle();
            check_eq($sformatf("sim%0d_data", i), 32'(data_ds), 32'(i - 4));
            check_eq($sformatf("sim%0d_valid", i), 32'(valid_ds), 32'h1);
            tick();
            settle();
            check_eq($sformatf("sim%0d_count", i), 32'(count), 32'h4);
            check_eq($sformatf("sim%0d_overflow", i), 32'(overflow), 32'h0);
        end
        valid_us = 1'b0;
        settle();
        for (int i = 3; i <= 6; i++) begin
            check_eq($sformatf("simdrain%0d", i), 32'(data_ds), 32'(i));
            check_eq($sformatf("simdrain%0d_v", i), 32'(valid_ds), 32'h1);
            tick();
            settle();
        end
        check_eq("sim_empty", 32'(valid_ds), 32'h0);

        // Continuous streaming across pointer wrap: each item appears one cycle later.
        for (int i = 0; i < 10; i++) begin
            valid_us = 1'b1;
            data_us  = 8'(i);
            tick();
            settle();
            check_eq($sformatf("stream%0d_v", i), 32'(valid_ds), 32'h1);
            check_eq($sformatf("stream%0d_d", i), 32'(data_ds), 32'(i));
            check_eq($sformatf("stream%0d_c", i), 32'(count), 32'h1);
        end
        valid_us = 1'b0;
        tick();
        settle();
        check_state("stream_end", 3'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-operation, asserted between edges.
        stall_ds = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_us = 1'b1;
            data_us  = 8'(8'hC0 + i);
            tick();
        end
        valid_us = 1'b0;
        #2;
        check_eq("pre_rst_count", 32'(count), 32'h3);
        stall_ds = 1'b0;
        rst      = 1'b0;
        #1;
        check_state("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
        check_eq("async_rst_data", 32'(data_ds), 32'h0);
        tick();
        rst = 1'b1;
        settle();
        valid_us = 1'b1;
        data_us  = 8'h7E;
        tick();
        valid_us = 1'b0;
        settle();
        check_eq("post_rst_valid", 32'(valid_ds), 32'h1);
        check_eq("post_rst_data", 32'(data_ds), 32'h7E);
        check_eq("post_rst_count", 32'(count), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
